ldtu_word_packer: RTL and testbench

Packs the LiTe-DTU sample stream into 32-bit output words for the serializer. Each sample arrives with a baseline/signal classification. Baseline samples are packed as 6-bit values, five per word; signal samples are packed as 13-bit values, two per word. Partial words are flushed whenever the classification changes or an orbit marker is due. Words go through an 8-deep output FIFO with a valid/ready handshake to the serializer.

---
 rtl/ldtu_word_packer_if.sv | 27 ++
 rtl/ldtu_word_packer.sv | 160 ++++++++++++++++
 tb/tb_ldtu_word_packer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/ldtu_word_packer_if.sv
// ldtu_word_packer_if: sample-in / word-out bundle for the LiTe-DTU word packer.
//   sample_en, DATA_in, baseline_flag : classified sample stream into the packer
//   Orbit                             : single-cycle BC0 pulse
//   word_ready                        : serializer accepts word_out this cycle
//   word_out, word_valid              : FIFO head word and non-empty flag
//   fifo_ovf                          : sticky dropped-word flag
// The master side drives samples and ready; the slave side is the packer.
interface ldtu_word_packer_if;
  logic        sample_en;
  logic [12:0] DATA_in;
  logic        baseline_flag;
  logic        Orbit;
  logic        word_ready;
  logic [31:0] word_out;
  logic        word_valid;
  logic        fifo_ovf;

  modport master (
    output sample_en, DATA_in, baseline_flag, Orbit, word_ready,
    input  word_out, word_valid, fifo_ovf
  );

  modport slave (
    input  sample_en, DATA_in, baseline_flag, Orbit, word_ready,
    output word_out, word_valid, fifo_ovf
  );
endinterface

// File: rtl/ldtu_word_packer.sv
// ldtu_word_packer: packs baseline (6-bit, five per word) and signal (13-bit, two per word)
// samples into 32-bit words, flushing partial words on a class change or orbit marker, and
// queues them in a FIFO_DEPTH-entry output FIFO with a valid/ready handshake.
//   CLK    : clock, all state on the rising edge
//   rst_b  : asynchronous active-low reset
//   bus_io : sample stream in, word stream out, sticky overflow (see ldtu_word_packer_if)
module ldtu_word_packer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned OCNT_W     = 12
) (
  input logic               CLK,
  input logic               rst_b,
  ldtu_word_packer_if.slave bus_io
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DepthCnt = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StEmpty, StBase, StSign} mode_e;

  mode_e             mode_q, mode_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [29:0]       pay_q, pay_d;
  logic [OCNT_W-1:0] ocnt_q, ocnt_d;

  // Up to two ordered pushes per cycle: push_w0 is always the older one.
  logic [1:0]        n_push;
  logic [31:0]       push_w0, push_w1;
  logic [31:0]       flush_w, marker_w, full_w;

  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, wr_ptr_nx, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d, free_slots;
  logic              pop, acc0, acc1, drop;
  logic              ovf_q, ovf_d;

  // State register
  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      mode_q   <= StEmpty;
      cnt_q    <= '0;
      pay_q    <= '0;
      ocnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      pay_q    <= pay_d;
      ocnt_q   <= ocnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage needs no reset: the head is gated by count_q.
  always_ff @(posedge CLK) begin
    if (acc0) mem_q[wr_ptr_q] <= push_w0;
    if (acc1) mem_q[wr_ptr_nx] <= push_w1;
  end

  // Partial word for the accumulator as it stood at the start of the cycle; both flush
  // points (orbit, class switch) see that state, since the orbit leaves MODE empty.
  always_comb begin
    if (mode_q == StSign) flush_w = {6'b001011, 13'd0, pay_q[12:0]};
    else                  flush_w = {5'b11000, cnt_q, pay_q[23:0]};
    marker_w = 32'hE000_0000 | 32'(ocnt_q);
  end

  // Next-state: orbit, class switch, append, in that order.
  always_comb begin
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    pay_d   = pay_q;
    ocnt_d  = ocnt_q;
    n_push  = 2'd0;
    push_w0 = '0;
    push_w1 = '0;
    full_w  = '0;

    if (bus_io.Orbit) begin
      if (mode_q != StEmpty) begin
        push_w0 = flush_w;
        n_push  = 2'd1;
      end
      if (n_push == 2'd0) push_w0 = marker_w;
      else                push_w1 = marker_w;
      n_push = n_push + 2'd1;
      ocnt_d = ocnt_q + OCNT_W'(1);
      mode_d = StEmpty;
      cnt_d  = '0;
      pay_d  = '0;
    end

    if (bus_io.sample_en) begin
      // Only reachable without an orbit, so this is always the first push.
      if (mode_d != StEmpty && ((mode_d == StBase) != bus_io.baseline_flag)) begin
        push_w0 = flush_w;
        n_push  = 2'd1;
        mode_d  = StEmpty;
        cnt_d   = '0;
        pay_d   = '0;
      end

      if (bus_io.baseline_flag) begin
        case (cnt_d)
          3'd0:    pay_d[5:0]   = bus_io.DATA_in[5:0];
          3'd1:    pay_d[11:6]  = bus_io.DATA_in[5:0];
          3'd2:    pay_d[17:12] = bus_io.DATA_in[5:0];
          3'd3:    pay_d[23:18] = bus_io.DATA_in[5:0];
          default: pay_d[29:24] = bus_io.DATA_in[5:0];
        endcase
        full_w = {2'b01, pay_d};
      end else begin
        if (cnt_d == 3'd0) pay_d[12:0]  = bus_io.DATA_in;
        else               pay_d[25:13] = bus_io.DATA_in;
        full_w = {6'b001010, pay_d[25:0]};
      end

      if ((bus_io.baseline_flag && cnt_d == 3'd4) ||
          (!bus_io.baseline_flag && cnt_d == 3'd1)) begin
        if (n_push == 2'd0) push_w0 = full_w;
        else                push_w1 = full_w;
        n_push = n_push + 2'd1;
        mode_d = StEmpty;
        cnt_d  = '0;
        pay_d  = '0;
      end else begin
        mode_d = bus_io.baseline_flag ? StBase : StSign;
        cnt_d  = cnt_d + 3'd1;
      end
    end
  end

  // FIFO bookkeeping: a same-cycle pop frees one slot for this cycle's pushes.
  always_comb begin
    pop        = (count_q != '0) && bus_io.word_ready;
    free_slots = DepthCnt - count_q + (AW+1)'(pop);
    acc0       = (n_push != 2'd0) && (free_slots >= (AW+1)'(1));
    acc1       = (n_push == 2'd2) && (free_slots >= (AW+1)'(2));
    drop       = ((n_push != 2'd0) && !acc0) || ((n_push == 2'd2) && !acc1);
    wr_ptr_nx  = wr_ptr_q + AW'(1);
    wr_ptr_d   = wr_ptr_q + AW'(acc0) + AW'(acc1);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + (AW+1)'(acc0) + (AW+1)'(acc1) - (AW+1)'(pop);
    ovf_d      = ovf_q | drop;
  end

  // Outputs
  always_comb begin
    bus_io.word_valid = (count_q != '0);
    bus_io.word_out   = (count_q != '0) ? mem_q[rd_ptr_q] : 32'h0;
    bus_io.fifo_ovf   = ovf_q;
  end

endmodule

// File: tb/tb_ldtu_word_packer.sv
// tb_ldtu_word_packer: directed-vector bench for ldtu_word_packer. Inputs change 1 time unit
// after the rising edge; popped words are captured on the falling edge.
module tb_ldtu_word_packer;

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  ldtu_word_packer_if bus ();

  ldtu_word_packer #(
    .FIFO_DEPTH (8),
    .OCNT_W     (12)
  ) dut (
    .CLK    (clk),
    .rst_b  (rst_b),
    .bus_io (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    if (rst_b && bus.word_valid && bus.word_ready) got_q.push_back(bus.word_out);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Compare captured words against exp_q in order, then clear both.
  task automatic check_stream(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic step(input logic en, input logic [12:0] d, input logic bl, input logic orb);
    bus.sample_en     = en;
    bus.DATA_in       = d;
    bus.baseline_flag = bl;
    bus.Orbit         = orb;
    @(posedge clk);
    #1;
    bus.sample_en = 1'b0;
    bus.Orbit     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 13'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_b             = 1'b0;
    bus.sample_en     = 1'b0;
    bus.DATA_in       = '0;
    bus.baseline_flag = 1'b0;
    bus.Orbit         = 1'b0;
    bus.word_ready    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_b = 1'b1;
    @(posedge clk);
    #1;

    check("rst_valid", 32'(bus.word_valid), 32'd0);
    check("rst_word",  bus.word_out,        32'h0);
    check("rst_ovf",   32'(bus.fifo_ovf),   32'd0);

    // Five baseline samples -> one full word, visible one cycle after the fifth.
    bus.word_ready = 1'b1;
    for (int i = 1; i <= 4; i++) step(1'b1, 13'(i), 1'b1, 1'b0);
    check("base_no_early", 32'(bus.word_valid), 32'd0);
    step(1'b1, 13'd5, 1'b1, 1'b0);
    check("base_valid", 32'(bus.word_valid), 32'd1);
    check("base_word",  bus.word_out, {2'b01, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1});
    idle(3);
    exp_q.push_back({2'b01, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1});
    check_stream("base");

    // Signal packing with a class switch; 13'h1111 stays pending.
    step(1'b1, 13'h1ABC, 1'b0, 1'b0);
    step(1'b1, 13'h0123, 1'b0, 1'b0);
    step(1'b1, 13'h003F, 1'b1, 1'b0);
    step(1'b1, 13'h0FFF, 1'b0, 1'b0);
    step(1'b1, 13'h0555, 1'b0, 1'b0);
    step(1'b1, 13'h1111, 1'b0, 1'b0);
    idle(3);
    exp_q.push_back({6'b001010, 13'h0123, 13'h1ABC});
    exp_q.push_back({5'b11000, 3'd1, 18'd0, 6'h3F});
    exp_q.push_back({6'b001010, 13'h0555, 13'h0FFF});
    check_stream("switch");

    // Orbit flush: pending signal flushed by baseline, then orbit with a same-cycle sample,
    // then an orbit alone flushing the single pending baseline.
    step(1'b1, 13'd7, 1'b1, 1'b0);
    step(1'b1, 13'd8, 1'b1, 1'b0);
    step(1'b1, 13'd9, 1'b1, 1'b0);
    step(1'b1, 13'd10, 1'b1, 1'b1);
    idle(2);
    step(1'b0, 13'd0, 1'b0, 1'b1);
    idle(3);
    exp_q.push_back({6'b001011, 13'd0, 13'h1111});
    exp_q.push_back({5'b11000, 3'd3, 6'd0, 6'd9, 6'd8, 6'd7});
    exp_q.push_back(32'hE000_0000);
    exp_q.push_back({5'b11000, 3'd1, 18'd0, 6'd10});
    exp_q.push_back(32'hE000_0001);
    check_stream("orbit");

    // Backpressure: ten full signal words into an 8-deep FIFO.
    check("ovf_before_fill", 32'(bus.fifo_ovf), 32'd0);
    bus.word_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 13'(13'h100 + k), 1'b0, 1'b0);
      step(1'b1, 13'(13'h200 + k), 1'b0, 1'b0);
      if (k == 7) check("ovf_at_full", 32'(bus.fifo_ovf), 32'd0);
      if (k == 8) check("ovf_on_drop", 32'(bus.fifo_ovf), 32'd1);
    end
    check("bp_head_stable", bus.word_out, {6'b001010, 13'h200, 13'h100});
    check("bp_no_pop", 32'(got_q.size()), 32'd0);
    // Push into a full FIFO in the same cycle as the first pop: accepted.
    step(1'b1, 13'h0AA, 1'b0, 1'b0);
    bus.word_ready = 1'b1;
    step(1'b1, 13'h0BB, 1'b0, 1'b0);
    idle(12);
    for (int k = 0; k < 8; k++) exp_q.push_back({6'b001010, 13'(13'h200 + k), 13'(13'h100 + k)});
    exp_q.push_back({6'b001010, 13'h0BB, 13'h0AA});
    check_stream("drain");
    check("ovf_sticky", 32'(bus.fifo_ovf), 32'd1);

    // Async reset with three queued words and a pending baseline partial.
    bus.word_ready = 1'b0;
    for (int k = 0; k < 6; k++) step(1'b1, 13'(13'h300 + k), 1'b0, 1'b0);
    step(1'b1, 13'h02A, 1'b1, 1'b0);
    check("pre_rst_valid", 32'(bus.word_valid), 32'd1);
    #2;
    rst_b = 1'b0;
    #1;
    check("arst_valid", 32'(bus.word_valid), 32'd0);
    check("arst_word",  bus.word_out,        32'h0);
    check("arst_ovf",   32'(bus.fifo_ovf),   32'd0);
    @(negedge clk) rst_b = 1'b1;
    @(posedge clk);
    #1;
    bus.word_ready = 1'b1;
    step(1'b0, 13'd0, 1'b0, 1'b1);
    idle(3);
    exp_q.push_back(32'hE000_0000);
    check_stream("post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
